// File: rtl/umi_sim_pkg.sv
// Shared types for the UMI simulation endpoint blocks.
package umi_sim_pkg;

    localparam int UMI_PACKET_W = 256;

    typedef logic [UMI_PACKET_W-1:0] umi_packet_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } umi_tx_state_t;

endpackage

// File: rtl/umi_fifo_ram.sv
// DEPTH x DW packet storage: one synchronous write port and an asynchronous read port.
module umi_fifo_ram #(
    parameter int DW    = 256,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem_r [DEPTH];

    // Storage write; contents are unreset because the occupancy count gates every use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/umi_tx_buffer.sv
// Elastic FIFO in front of the UMI TX endpoint: holds the head packet stable until the endpoint's ready pulse.
module umi_tx_buffer
    import umi_sim_pkg::*;
#(
    parameter int DW    = UMI_PACKET_W,
    parameter int DEPTH = 4,
    parameter int CNTW  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DW-1:0]          in_packet,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [DW-1:0]          out_packet,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNTW-1:0]        sent_cnt,
    output logic [CNTW-1:0]        stall_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    umi_tx_state_t state_r;
    umi_tx_state_t state_next_s;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          in_ready_r;
    logic [CNTW-1:0] sent_r;
    logic [CNTW-1:0] stall_r;
    logic          push_s;
    logic          pop_s;

    assign push_s       = in_valid && in_ready_r;
    assign pop_s        = (state_r == WAIT) && out_ready;
    assign count_next_s = count_r + CW'(push_s) - CW'(pop_s);

    umi_fifo_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (in_packet),
        .raddr (rd_ptr_r),
        .rdata (out_packet)
    );

    // Next state looks at post-update occupancy so a fresh push is presented one cycle later.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, WAIT: begin
                if (count_next_s != {CW{1'b0}}) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, pointers, occupancy and the registered accept flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            count_r    <= count_next_s;
            in_ready_r <= (count_next_s != CW'(DEPTH));
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
        end
    end

    // Statistics: sent count wraps, stall count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_r  <= {CNTW{1'b0}};
            stall_r <= {CNTW{1'b0}};
        end else begin
            if (pop_s) begin
                sent_r <= sent_r + CNTW'(1'b1);
            end
            if ((state_r == WAIT) && !out_ready && (stall_r != {CNTW{1'b1}})) begin
                stall_r <= stall_r + CNTW'(1'b1);
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = (state_r == WAIT);
    assign count     = count_r;
    assign sent_cnt  = sent_r;
    assign stall_cnt = stall_r;

endmodule

// File: tb/tb_umi_tx_buffer.sv
// Directed bench for umi_tx_buffer: vector table plus hand-written multi-cycle sequences.
module tb_umi_tx_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [255:0] in_packet;
    logic         out_ready;
    logic         in_ready, out_valid;
    logic [255:0] out_packet;
    logic [2:0]   count;
    logic [31:0]  sent_cnt, stall_cnt;
    logic         s_in_ready, s_out_valid;
    logic [255:0] s_out_packet;
    logic [2:0]   s_count;
    logic [3:0]   s_sent_cnt, s_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    umi_tx_buffer #(.DW(256), .DEPTH(4), .CNTW(32)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_packet(in_packet),
        .in_ready(in_ready), .out_valid(out_valid), .out_packet(out_packet),
        .out_ready(out_ready), .count(count), .sent_cnt(sent_cnt), .stall_cnt(stall_cnt)
    );

    umi_tx_buffer #(.DW(256), .DEPTH(4), .CNTW(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_packet(in_packet),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_packet(s_out_packet),
        .out_ready(out_ready), .count(s_count), .sent_cnt(s_sent_cnt), .stall_cnt(s_stall_cnt)
    );

    typedef struct {
        logic         iv;
        logic [255:0] pkt;
        logic         ordy;
        logic         e_ir;
        logic         e_ov;
        logic [2:0]   e_cnt;
        logic [255:0] e_pkt;
        logic [31:0]  e_sent;
        logic [31:0]  e_stall;
    } vec_t;

    vec_t tbl [17];

    function automatic logic [255:0] pk(input int i);
        return {8{32'hC0DE_0000 | 32'(i)}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [255:0] p, input logic r);
        in_valid  = v;
        in_packet = p;
        out_ready = r;
    endtask

    initial begin
        logic [255:0] a5;
        logic [255:0] z;
        a5 = {32{8'hA5}};
        z  = 256'h0;
        // Single packet, then fill past full and drain (rows: inputs, then expected current-cycle outputs).
        tbl[0]  = '{1'b1, a5,    1'b0, 1'b1, 1'b0, 3'd0, z,     32'd0, 32'd0};
        tbl[1]  = '{1'b0, z,     1'b0, 1'b1, 1'b1, 3'd1, a5,    32'd0, 32'd0};
        tbl[2]  = '{1'b0, z,     1'b0, 1'b1, 1'b1, 3'd1, a5,    32'd0, 32'd1};
        tbl[3]  = '{1'b0, z,     1'b1, 1'b1, 1'b1, 3'd1, a5,    32'd0, 32'd2};
        tbl[4]  = '{1'b1, pk(0), 1'b0, 1'b1, 1'b0, 3'd0, z,     32'd1, 32'd2};
        tbl[5]  = '{1'b1, pk(1), 1'b0, 1'b1, 1'b1, 3'd1, pk(0), 32'd1, 32'd2};
        tbl[6]  = '{1'b1, pk(2), 1'b0, 1'b1, 1'b1, 3'd2, pk(0), 32'd1, 32'd3};
        tbl[7]  = '{1'b1, pk(3), 1'b0, 1'b1, 1'b1, 3'd3, pk(0), 32'd1, 32'd4};
        tbl[8]  = '{1'b1, pk(4), 1'b0, 1'b0, 1'b1, 3'd4, pk(0), 32'd1, 32'd5};
        tbl[9]  = '{1'b1, pk(4), 1'b1, 1'b0, 1'b1, 3'd4, pk(0), 32'd1, 32'd6};
        tbl[10] = '{1'b1, pk(4), 1'b0, 1'b1, 1'b1, 3'd3, pk(1), 32'd2, 32'd6};
        tbl[11] = '{1'b0, z,     1'b1, 1'b0, 1'b1, 3'd4, pk(1), 32'd2, 32'd7};
        tbl[12] = '{1'b0, z,     1'b0, 1'b1, 1'b1, 3'd3, pk(2), 32'd3, 32'd7};
        tbl[13] = '{1'b0, z,     1'b1, 1'b1, 1'b1, 3'd3, pk(2), 32'd3, 32'd8};
        tbl[14] = '{1'b0, z,     1'b1, 1'b1, 1'b1, 3'd2, pk(3), 32'd4, 32'd8};
        tbl[15] = '{1'b0, z,     1'b1, 1'b1, 1'b1, 3'd1, pk(4), 32'd5, 32'd8};
        tbl[16] = '{1'b0, z,     1'b0, 1'b1, 1'b0, 3'd0, z,     32'd6, 32'd8};

        rst = 1'b1;
        drive(1'b0, z, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d in_ready", i), 256'(in_ready), 256'(tbl[i].e_ir));
            chk($sformatf("tbl%0d out_valid", i), 256'(out_valid), 256'(tbl[i].e_ov));
            chk($sformatf("tbl%0d count", i), 256'(count), 256'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d sent_cnt", i), 256'(sent_cnt), 256'(tbl[i].e_sent));
            chk($sformatf("tbl%0d stall_cnt", i), 256'(stall_cnt), 256'(tbl[i].e_stall));
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d out_packet", i), out_packet, tbl[i].e_pkt);
            end
            drive(tbl[i].iv, tbl[i].pkt, tbl[i].ordy);
        end

        // Back-to-back: four queued, endpoint pulses every second cycle.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, pk(16 + i), 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("b2b%0d out_valid", k), 256'(out_valid), 256'(1'b1));
            chk($sformatf("b2b%0d out_packet", k), out_packet, pk(16 + k / 2));
            drive(1'b0, z, (k % 2) == 1);
        end
        @(negedge clk);
        chk("b2b end out_valid", 256'(out_valid), 256'(1'b0));
        chk("b2b end count", 256'(count), 256'(3'd0));
        chk("b2b end sent_cnt", 256'(sent_cnt), 256'(32'd10));
        drive(1'b0, z, 1'b0);

        // Simultaneous push and pop at count 3, pointers wrap several times.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, pk(32 + i), 1'b0);
        end
        for (int it = 0; it < 10; it++) begin
            @(negedge clk);
            chk($sformatf("pp%0d count", it), 256'(count), 256'(3'd3));
            chk($sformatf("pp%0d out_packet", it), out_packet, pk(32 + it));
            drive(1'b1, pk(35 + it), 1'b1);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("ppdrain%0d out_packet", k), out_packet, pk(42 + k));
            drive(1'b0, z, 1'b1);
        end
        @(negedge clk);
        chk("pp end count", 256'(count), 256'(3'd0));
        chk("pp end out_valid", 256'(out_valid), 256'(1'b0));
        chk("pp end sent_cnt", 256'(sent_cnt), 256'(32'd23));
        drive(1'b0, z, 1'b0);

        // Reset mid-WAIT with three queued, then a stray ready pulse.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, pk(48 + i), 1'b0);
        end
        @(negedge clk);
        drive(1'b0, z, 1'b0);
        @(negedge clk);
        chk("prerst count", 256'(count), 256'(3'd3));
        chk("prerst out_valid", 256'(out_valid), 256'(1'b1));
        rst = 1'b1;
        drive(1'b1, pk(60), 1'b1);
        @(negedge clk);
        rst = 1'b0;
        chk("rst count", 256'(count), 256'(3'd0));
        chk("rst out_valid", 256'(out_valid), 256'(1'b0));
        chk("rst in_ready", 256'(in_ready), 256'(1'b1));
        chk("rst sent_cnt", 256'(sent_cnt), 256'(32'd0));
        chk("rst stall_cnt", 256'(stall_cnt), 256'(32'd0));
        drive(1'b0, z, 1'b1);
        @(negedge clk);
        chk("idle ready count", 256'(count), 256'(3'd0));
        chk("idle ready out_valid", 256'(out_valid), 256'(1'b0));
        chk("idle ready sent_cnt", 256'(sent_cnt), 256'(32'd0));
        chk("idle ready stall_cnt", 256'(stall_cnt), 256'(32'd0));
        drive(1'b0, z, 1'b0);

        // Stall saturation on the 4-bit counter instance.
        @(negedge clk);
        drive(1'b1, pk(64), 1'b0);
        repeat (15) begin
            @(negedge clk);
            drive(1'b0, z, 1'b0);
        end
        @(negedge clk);
        chk("sat15 narrow stall", 256'(s_stall_cnt), 256'(4'hF));
        chk("sat15 wide stall", 256'(stall_cnt), 256'(32'd15));
        repeat (5) @(negedge clk);
        chk("sat20 narrow stall", 256'(s_stall_cnt), 256'(4'hF));
        chk("sat20 wide stall", 256'(stall_cnt), 256'(32'd20));
        chk("sat20 out_packet", out_packet, pk(64));
        drive(1'b0, z, 1'b1);
        @(negedge clk);
        drive(1'b0, z, 1'b0);
        chk("sat pop narrow sent", 256'(s_sent_cnt), 256'(4'd1));
        chk("sat pop wide sent", 256'(sent_cnt), 256'(32'd1));
        chk("sat pop out_valid", 256'(out_valid), 256'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
